bram_tdp_bytewe: RTL
====================

// Module: bram_tdp_bytewe
// PURPOSE
//  True dual-port block RAM, ports A and B on one clock. Each port has a
//  selectable write mode: READ_FIRST, WRITE_FIRST or NO_CHANGE.
//  Adds per-byte write enables, an optional output pipeline register and an
//  async-reset output stage. Successor to the single-port READ_FIRST RAM;
//  used for shared buffers between two datapath engines.
// PARAMETERS
//  DATA_WIDTH  32  word width; must be a multiple of BYTE_WIDTH (else $error)
//  BYTE_WIDTH  8   bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
//  ADDR_WIDTH  10  address bits; depth = 1<<ADDR_WIDTH
//  WMODE_A     0   port A mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
//  WMODE_B     0   port B mode, same encoding
//  OUT_REG     0   1 = extra output register stage; read latency 1+OUT_REG
//  RST_VAL     0   value loaded into dout regs on reset
//  INIT_FILE   ""  non-empty: $readmemh into memory at elaboration
// PORTS
//  clka    in   1           shared clock for both ports, rising edge
//  rsta_n  in   1           async active-low reset
//  ena     in   1           port A enable; 0 = no read, no write, douta holds
//  wea     in   NB          port A byte write enables
//  addra   in   ADDR_WIDTH  port A address
//  dina    in   DATA_WIDTH  port A write data
//  douta   out  DATA_WIDTH  port A read data
//  enb/web/addrb/dinb/doutb  port B, same as port A
// BEHAVIOUR
//  - Reset: rsta_n=0 asynchronously forces douta, doutb and the OUT_REG
//    stage regs to RST_VAL. Memory contents are untouched. No write commits
//    on any edge while rsta_n=0. First valid read data appears 1+OUT_REG
//    edges after the first enabled edge following deassertion.
//  - Write: on an edge with en=1, each byte lane i with we[i]=1 takes
//    din[i*BYTE_WIDTH +: BYTE_WIDTH]. Lanes with we[i]=0 keep old data.
//  - Read stage 1, per port, on an edge with en=1:
//      READ_FIRST : dout1 <= mem[addr] before the write.
//      WRITE_FIRST: dout1 <= byte-merged word (new lanes, old others).
//      NO_CHANGE  : dout1 holds if |we; else dout1 <= mem[addr].
//    en=0: dout1 holds.
//  - OUT_REG=1: dout <= dout1 on every edge, independent of en.
//    OUT_REG=0: dout is dout1.
//  - Collision, same address, same edge:
//      both ports write: lane written by both -> port A data wins;
//      lanes written by one port only -> that port's data.
//    Cross-port read: a port reading the address the other port writes
//    returns pre-write data, regardless of mode. WRITE_FIRST bypass applies
//    to the port's own write only.
//  - Addresses are always in range (full power-of-2 depth); no wrap logic.
//  - No combinational path from any input to douta/doutb.
// TESTING
//  1 Reset: rsta_n=0 mid-stream with RST_VAL=16'hDEAD -> douta=doutb=DEAD
//    immediately. A write issued during reset does not commit: readback
//    after reset shows the old value.
//  2 Modes: mem[5]=0x11111111; A writes 0x22222222 @5, we=4'hF.
//    READ_FIRST douta=0x11111111; WRITE_FIRST 0x22222222; NO_CHANGE prior
//    douta held. Next read @5 = 0x22222222 in all modes.
//  3 Byte enables: mem[7]=0xAABBCCDD; write 0x11223344, we=4'b0101 ->
//    readback 0xAA22CC44.
//  4 Collision: A writes 0x0000FFFF we=4'b0011, B writes 0xFFFF0000
//    we=4'b1111, both @9 -> mem[9]=0xFFFFFFFF. Same test with A we=4'hF ->
//    0x0000FFFF. Cross-read: B reads @9 while A writes -> old value.
//  5 OUT_REG=1: read @3 holding 0x5A at edge N -> dout=0x5A after edge N+1,
//    not after N. en=0 on edge N+1 -> stage 1 holds; dout tracks stage 1.
//  6 Random: 10k cycles of random en/we/addr on both ports vs a reference
//    model with the collision rules above -> zero mismatches, all modes,
//    OUT_REG 0 and 1.

Source files
------------

// File: rtl/bram_tdp_bytewe_if.sv
// One port of the true dual-port RAM: enable, byte write enables, address, data in/out.
interface bram_tdp_bytewe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  en;
  logic [NB-1:0]         we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output en, output we, output addr, output din, input dout);
  modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/bram_tdp_bytewe.sv
// True dual-port block RAM on one clock with byte write enables, per-port
// READ_FIRST / WRITE_FIRST / NO_CHANGE modes and an optional output register.
module bram_tdp_bytewe #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BYTE_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           WMODE_A    = 0,
  parameter int unsigned           WMODE_B    = 0,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
  parameter string                 INIT_FILE  = ""
) (
  input logic              clka,
  input logic              rsta_n,
  bram_tdp_bytewe_if.slave porta,
  bram_tdp_bytewe_if.slave portb
);
  localparam int unsigned NB          = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
  localparam int unsigned WRITE_FIRST = 1;
  localparam int unsigned NO_CHANGE   = 2;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("bram_tdp_bytewe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_a_c, rd_b_c;
  logic [DATA_WIDTH-1:0] mrg_a_c, mrg_b_c;
  logic [DATA_WIDTH-1:0] nxt_a_c, nxt_b_c;
  logic [DATA_WIDTH-1:0] dout1_a, dout1_b;

  // Stage-1 next value; the merged word only ever carries this port's own lanes.
  function automatic logic [DATA_WIDTH-1:0] stage1_next(
    input int unsigned           mode,
    input logic [DATA_WIDTH-1:0] held,
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] merged,
    input logic                  wr
  );
    case (mode)
      WRITE_FIRST: return merged;
      NO_CHANGE:   return wr ? held : old;
      default:     return old;
    endcase
  endfunction

  always_comb begin
    rd_a_c  = mem[porta.addr];
    rd_b_c  = mem[portb.addr];
    mrg_a_c = rd_a_c;
    mrg_b_c = rd_b_c;
    for (int unsigned i = 0; i < NB; i++) begin
      if (porta.we[i]) mrg_a_c[i*BYTE_WIDTH +: BYTE_WIDTH] = porta.din[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (portb.we[i]) mrg_b_c[i*BYTE_WIDTH +: BYTE_WIDTH] = portb.din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    nxt_a_c = stage1_next(WMODE_A, dout1_a, rd_a_c, mrg_a_c, |porta.we);
    nxt_b_c = stage1_next(WMODE_B, dout1_b, rd_b_c, mrg_b_c, |portb.we);
  end

  // Stage-1 read regs and memory writes; reset blocks writes but leaves contents intact.
  // Port A lanes are written after port B so A wins a same-lane collision.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      dout1_a <= RST_VAL;
      dout1_b <= RST_VAL;
    end else begin
      if (porta.en) dout1_a <= nxt_a_c;
      if (portb.en) dout1_b <= nxt_b_c;
      for (int unsigned i = 0; i < NB; i++) begin
        if (portb.en && portb.we[i])
          mem[portb.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= portb.din[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (porta.en && porta.we[i])
          mem[porta.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= porta.din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    // Output stage follows stage 1 every edge regardless of enable.
    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
        porta.dout <= RST_VAL;
        portb.dout <= RST_VAL;
      end else begin
        porta.dout <= dout1_a;
        portb.dout <= dout1_b;
      end
    end
  end else begin : g_noreg
    assign porta.dout = dout1_a;
    assign portb.dout = dout1_b;
  end
endmodule
